// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_t;

  // Low two bits of a 32-bit (non-compressed) instruction.
  localparam logic [1:0] INSTR_LEN32 = 2'b11;

  // Default geometry: 64-word memory, program ends after 8 zero words.
  localparam int DEF_ADDR_W     = 6;
  localparam int DEF_ZERO_LIMIT = 8;

endpackage

// File: rtl/im_word_sel.sv
// Picks the addressed word out of the memory's 64-bit word pair and
// classifies it (compressed / all-zero padding).
module im_word_sel
  import fetch_pkg::*;
(
  input  logic [63:0] IR,
  input  logic        pc_lsb,
  output logic [31:0] word,
  output logic        is_c,
  output logic        is_zero
);

  // Even word lives in the upper half of the pair, odd word in the lower half.
  always_comb begin
    word    = pc_lsb ? IR[31:0] : IR[63:32];
    is_c    = (word[1:0] != INSTR_LEN32);
    is_zero = (word == 32'h0);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the word PC, skips zero padding, halts at
// end of program and presents one instruction per cycle to decode.
//
// Output handshake: out_valid/out_instr/out_is_c/out_pc form a registered
// valid/ready stage. A transfer happens on a rising edge where out_valid and
// out_ready are both high. While out_valid=1 and out_ready=0 the payload is
// held stable. out_valid only falls after a transfer, or when a redirect
// discards the held instruction, or on reset.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int ZERO_LIMIT = DEF_ZERO_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] PC_Sel,
  input  logic [63:0]       IR,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic              out_is_c,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted,
  output logic [1:0]        state_dbg
);

  localparam int ZW = $clog2(ZERO_LIMIT + 1);
  localparam logic [ADDR_W-1:0] PC_LAST = '1;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1);
  localparam logic [ZW-1:0]     ZC_LAST = ZW'(ZERO_LIMIT - 1);
  localparam logic [ZW-1:0]     ZC_STEP = ZW'(1);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ZW-1:0]     zero_cnt;
  logic [31:0]       word;
  logic              is_c, is_zero;
  logic              adv, end_prog;

  im_word_sel u_word_sel (
    .IR      (IR),
    .pc_lsb  (pc[0]),
    .word    (word),
    .is_c    (is_c),
    .is_zero (is_zero)
  );

  assign PC_Sel    = pc;
  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Advance/end-of-program decode and next-state selection; redirect wins.
  always_comb begin
    state_nxt = state;
    adv       = (state == S_FETCH) && run && (!out_valid || out_ready);
    end_prog  = adv && ((pc == PC_LAST) || (is_zero && (zero_cnt == ZC_LAST)));
    if (redirect_valid) begin
      state_nxt = run ? S_FETCH : S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (run) state_nxt = S_FETCH;
        S_FETCH: begin
          if (end_prog)  state_nxt = S_HALT;
          else if (!run) state_nxt = S_IDLE;
        end
        S_HALT:  state_nxt = S_HALT;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // PC, zero-run counter, halt flag and the registered decode-facing payload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= '0;
      zero_cnt  <= '0;
      halted    <= 1'b0;
      out_valid <= 1'b0;
      out_instr <= 32'h0;
      out_is_c  <= 1'b0;
      out_pc    <= '0;
    end else if (redirect_valid) begin
      pc        <= redirect_pc;
      zero_cnt  <= '0;
      halted    <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      pc <= pc + PC_STEP;
      if (is_zero) begin
        zero_cnt  <= zero_cnt + ZC_STEP;
        out_valid <= 1'b0;
      end else begin
        zero_cnt  <= '0;
        out_valid <= 1'b1;
        out_instr <= is_c ? {16'h0, word[15:0]} : word;
        out_is_c  <= is_c;
        out_pc    <= pc;
      end
      if (end_prog) halted <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized
// programs, backpressure and redirects against a program-walk reference model.
module tb_fetch_ctrl;

  localparam int W = 39; // {pc[5:0], is_c, instr[31:0]}

  logic        clk;
  logic        reset;
  logic        run;
  logic [5:0]  PC_Sel;
  logic [63:0] IR;
  logic        redirect_valid;
  logic [5:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_is_c;
  logic [5:0]  out_pc;
  logic        halted;
  logic [1:0]  state_dbg;

  logic [31:0]  mem [64];
  logic [W-1:0] exp_q [$];
  logic [5:0]   exp_halt_pc;
  logic [W-1:0] held;
  int           checks;
  int           failures;

  fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .PC_Sel         (PC_Sel),
    .IR             (IR),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_is_c       (out_is_c),
    .out_pc         (out_pc),
    .halted         (halted),
    .state_dbg      (state_dbg)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational memory returning the aligned word pair.
  always_comb IR = {mem[{PC_Sel[5:1], 1'b0}], mem[{PC_Sel[5:1], 1'b1}]};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_nz();
    logic [31:0] w;
    w = $urandom;
    if (w == 32'h0) w = 32'h13;
    return w;
  endfunction

  // Reference: walk the program from start, emitting every nonzero word,
  // stopping after 8 consecutive zeros or after the last memory word.
  function automatic void build_exp(input int start);
    int zeros;
    logic [31:0] w;
    logic c;
    zeros = 0;
    exp_q.delete();
    for (int i = start; i < 64; i++) begin
      w = mem[i];
      if (w == 32'h0) zeros++;
      else begin
        c = (w[1:0] != 2'b11);
        exp_q.push_back({6'(i), c, (c ? {16'h0, w[15:0]} : w)});
        zeros = 0;
      end
      if (zeros == 8 || i == 63) begin
        exp_halt_pc = 6'((i + 1) % 64);
        break;
      end
    end
  endfunction

  task automatic redirect_to(input int p);
    redirect_valid = 1'b1;
    redirect_pc    = 6'(p);
    build_exp(p);
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  // Scoreboard loop: random ready, optional random redirects, until halted and drained.
  task automatic run_prog(input int ready_pct, input int redir_budget);
    int cyc;
    int redirs;
    bit hold;
    logic [W-1:0] cur, hv, ev;
    cyc = 0;
    redirs = redir_budget;
    hold = 1'b0;
    hv = '0;
    while (!(halted === 1'b1 && out_valid === 1'b0 && exp_q.size() == 0) && cyc < 2000) begin
      cur = {out_pc, out_is_c, out_instr};
      if (hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", cur, hv);
      end
      out_ready      = ($urandom_range(99) < ready_pct);
      redirect_valid = 1'b0;
      if (redirs > 0 && $urandom_range(99) < 3) begin
        redirs--;
        redirect_valid = 1'b1;
        redirect_pc    = 6'($urandom_range(63));
        build_exp(int'(redirect_pc));
        hold = 1'b0;
      end else begin
        if (out_valid === 1'b1 && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL extra_xfer observed=%0h expected=none", cur);
          end else begin
            ev = exp_q.pop_front();
            check("xfer", cur, ev);
          end
        end
        hold = (out_valid === 1'b1) && !out_ready;
        hv   = cur;
      end
      @(negedge clk);
      cyc++;
    end
    redirect_valid = 1'b0;
    check("prog_budget", (cyc < 2000), 1);
    check("prog_halted", halted, 1);
    check("prog_halt_pc", PC_Sel, exp_halt_pc);
    check("prog_drained", exp_q.size(), 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    run = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    // Image 1: directed words, words 26..63 zero.
    for (int i = 0; i < 64; i++) mem[i] = (i < 26) ? rand_nz() : 32'h0;
    mem[0]  = 32'h0;
    mem[1]  = 32'h0000_40F9;
    mem[8]  = 32'h0;
    mem[12] = 32'h41C0_D213;
    mem[13] = 32'h0;

    // Reset state.
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_is_c", out_is_c, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_pc_sel", PC_Sel, 0);
    check("rst_halted", halted, 0);

    // Basic fetch from word 0 (zero) then word 1 (compressed).
    build_exp(0);
    run = 1'b1;
    out_ready = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check("bf_idle_valid", out_valid, 0);
    check("bf_idle_pc", PC_Sel, 0);
    @(negedge clk);
    check("bf_skip_valid", out_valid, 0);
    check("bf_skip_pc", PC_Sel, 1);
    @(negedge clk);
    check("bf_valid", out_valid, 1);
    check("bf_instr", out_instr, 32'h0000_40F9);
    check("bf_is_c", out_is_c, 1);
    check("bf_out_pc", out_pc, 1);
    run_prog(70, 0);

    // Full-width instruction at 12, zero at 13 skipped, 14 follows.
    out_ready = 1'b1;
    redirect_to(12);
    check("fw_halted_clr", halted, 0);
    check("fw_pc_sel", PC_Sel, 12);
    @(negedge clk);
    check("fw_valid", out_valid, 1);
    check("fw_out_pc", out_pc, 12);
    check("fw_is_c", out_is_c, 0);
    check("fw_instr", out_instr, 32'h41C0_D213);
    @(negedge clk);
    check("fw_bubble", out_valid, 0);
    check("fw_pc14", PC_Sel, 14);
    @(negedge clk);
    check("fw_next_valid", out_valid, 1);
    check("fw_next_pc", out_pc, 14);

    // Backpressure while word 7 is held.
    out_ready = 1'b0;
    redirect_to(7);
    check("bp_discard", out_valid, 0);
    @(negedge clk);
    check("bp_valid", out_valid, 1);
    check("bp_out_pc", out_pc, 7);
    check("bp_pc_sel", PC_Sel, 8);
    held = {out_pc, out_is_c, out_instr};
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_data", {out_pc, out_is_c, out_instr}, held);
      check("bp_hold_pc_sel", PC_Sel, 8);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_valid", out_valid, 0);
    check("bp_rel_pc_sel", PC_Sel, 9);
    @(negedge clk);
    check("bp_w9_valid", out_valid, 1);
    check("bp_w9_pc", out_pc, 9);

    // Redirect while an instruction is pending and out_ready=1.
    redirect_to(22);
    check("rd_dropped", out_valid, 0);
    check("rd_pc_sel", PC_Sel, 22);
    @(negedge clk);
    check("rd_valid", out_valid, 1);
    check("rd_out_pc", out_pc, 22);
    run_prog(70, 0);

    // Zero-run halt stays halted and silent, then redirect restarts it.
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("zh_valid", out_valid, 0);
      check("zh_halted", halted, 1);
      check("zh_pc_sel", PC_Sel, 34);
    end
    redirect_to(1);
    check("zh_restart_halted", halted, 0);
    check("zh_restart_pc", PC_Sel, 1);
    @(negedge clk);
    check("zh_restart_valid", out_valid, 1);
    check("zh_restart_out_pc", out_pc, 1);
    run_prog(50, 2);

    // Random programs with random backpressure and redirects.
    for (int k = 0; k < 8; k++) begin
      int p;
      for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(99) < 20) ? 32'h0 : rand_nz();
      if ($urandom_range(1) == 1) begin
        p = $urandom_range(55);
        for (int j = 0; j < 8; j++) mem[p + j] = 32'h0;
      end
      out_ready = 1'b1;
      redirect_to($urandom_range(63));
      run_prog($urandom_range(100, 30), 2);
    end

    // Async reset mid-cycle while holding the last word under backpressure.
    mem[63] = 32'hDEAD_BEEF;
    out_ready = 1'b0;
    redirect_to(63);
    @(negedge clk);
    check("ar_valid", out_valid, 1);
    check("ar_instr", out_instr, 32'hDEAD_BEEF);
    check("ar_halted", halted, 1);
    check("ar_wrap_pc", PC_Sel, 0);
    #2 reset = 1'b0;
    #1;
    check("ar_rst_valid", out_valid, 0);
    check("ar_rst_instr", out_instr, 0);
    check("ar_rst_out_pc", out_pc, 0);
    check("ar_rst_pc_sel", PC_Sel, 0);
    check("ar_rst_halted", halted, 0);
    #10 reset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
